mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory arbiter: FSM encoding and
// default line address/data widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one shared main memory port.
// One transaction runs at a time: IDLE -> BUSY_x -> DONE -> IDLE.
// Simultaneous requests go to D by fixed priority. Defining MEM_ARBITER_RR_EN
// switches this to round-robin with a one-bit "who goes next" pointer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              r_state;
  logic                r_mem_read, r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_i_rdata, r_d_rdata;
  logic                r_i_ready, r_d_ready;
  logic                w_d_req;
  logic                w_grant_d;

  assign w_d_req = d_read | d_write;

`ifdef MEM_ARBITER_RR_EN
  logic r_rr_d_next;

  // D wins a tie only when the pointer says it is D's turn.
  assign w_grant_d = w_d_req & (~i_read | r_rr_d_next);

  // Pointer flips to the opposite side of whoever was just granted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_rr_d_next <= 1'b1;
    else if (r_state == IDLE && w_grant_d)
      r_rr_d_next <= 1'b0;
    else if (r_state == IDLE && i_read)
      r_rr_d_next <= 1'b1;
  end
`else
  // Fixed priority: any D request beats a concurrent I request.
  assign w_grant_d = w_d_req;
`endif

  // Transaction FSM with registered memory command and cache responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_read  <= d_read;
            r_mem_write <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (i_read) begin
            r_state     <= BUSY_I;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_addr;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            r_state     <= DONE;
            r_i_rdata   <= mem_rdata;
            r_i_ready   <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        BUSY_D: begin
          // Write-backs also capture mem_rdata; d_rdata is don't-care then.
          if (mem_ready) begin
            r_state     <= DONE;
            r_d_rdata   <= mem_rdata;
            r_d_ready   <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        DONE: begin
          // No grant here: the finished requester drops its level this cycle.
          r_state   <= IDLE;
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow the MEM_ARBITER_RR_EN
// setting it is compiled with.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read, d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next command, checks it, answers after lat cycles, checks DONE.
  task automatic run_grant(input string tag, input bit is_d, input bit wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input int lat, input bit drop);
    int n = 0;
    while (!(mem_read | mem_write) && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_grant_seen"}, (n < 10), 1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_wr"}, mem_write, wr);
    chk({tag, "_rd"}, mem_read, !wr);
    if (wr) chk({tag, "_wdata"}, mem_wdata, wdata);
    for (int k = 1; k < lat; k++) begin
      tick();
      chk({tag, "_addr_hold"}, mem_addr, addr);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk({tag, "_d_ready"}, d_ready, is_d);
    chk({tag, "_i_ready"}, i_ready, !is_d);
    chk({tag, "_cmd_drop"}, (mem_read | mem_write), 0);
    if (!wr) begin
      if (is_d) chk({tag, "_d_rdata"}, d_rdata, rdata);
      else      chk({tag, "_i_rdata"}, i_rdata, rdata);
    end
    if (drop) begin
      if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
    end
    tick();
    chk({tag, "_ready_pulse_end"}, (i_ready | d_ready), 0);
  endtask

  initial begin
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    rst_n = 1'b0; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
    tick(); tick();

    // reset state
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_readies", {i_ready, d_ready}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    rst_n = 1'b1;
    tick();

    // single I read, memory answers 4 cycles after mem_read
    i_read = 1; i_addr = 28'h0000010;
    run_grant("iread", 0, 0, 28'h0000010, '0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 4, 1);

    // simultaneous I read + D write: D first, then I
    i_read = 1; i_addr = 28'h0000030;
    d_write = 1; d_addr = 28'h0000020; d_wdata = a5;
    run_grant("tie_d", 1, 1, 28'h0000020, a5, 128'h0, 2, 1);
    run_grant("tie_i", 0, 0, 28'h0000030, '0, 128'hCAFE, 2, 1);

    // three fresh pairs, both requesters drop after service
    for (int p = 0; p < 3; p++) begin
      i_read = 1; i_addr = 28'h100 + 28'(p);
      d_read = 1; d_addr = 28'h200 + 28'(p);
      run_grant("pair_d", 1, 0, 28'h200 + 28'(p), '0, 128'hD0 + 128'(p), 1, 1);
      run_grant("pair_i", 0, 0, 28'h100 + 28'(p), '0, 128'hE0 + 128'(p), 1, 1);
    end

    // both sides hold their requests continuously
    i_read = 1; i_addr = 28'h0000300;
    d_read = 1; d_addr = 28'h0000400;
`ifdef MEM_ARBITER_RR_EN
    run_grant("hold_1", 1, 0, 28'h0000400, '0, 128'hA1, 1, 0);
    run_grant("hold_2", 0, 0, 28'h0000300, '0, 128'hA2, 1, 0);
    run_grant("hold_3", 1, 0, 28'h0000400, '0, 128'hA3, 1, 1);
    run_grant("hold_4", 0, 0, 28'h0000300, '0, 128'hA4, 1, 1);
`else
    run_grant("hold_1", 1, 0, 28'h0000400, '0, 128'hA1, 1, 0);
    run_grant("hold_2", 1, 0, 28'h0000400, '0, 128'hA2, 1, 0);
    run_grant("hold_3", 1, 0, 28'h0000400, '0, 128'hA3, 1, 1);
    run_grant("hold_4", 0, 0, 28'h0000300, '0, 128'hA4, 1, 1);
`endif

    // reset during BUSY_D aborts without ready, re-issue completes
    d_read = 1; d_addr = 28'h0000040;
    tick();
    chk("rstmid_busy", mem_read, 1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_cmd", (mem_read | mem_write), 0);
    chk("rstmid_no_ready", d_ready, 0);
    chk("rstmid_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_no_ready2", d_ready, 0);
    run_grant("rstmid_reissue", 1, 0, 28'h0000040, '0, 128'hBEEF, 2, 1);

    // spurious mem_ready in IDLE is ignored
    mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("spur_cmd", (mem_read | mem_write), 0);
    tick();
    chk("spur_no_ready", {i_ready, d_ready}, 0);

    // d_addr changing while BUSY_D does not disturb mem_addr
    d_read = 1; d_addr = 28'h0000050;
    tick();
    chk("chg_grant", mem_read, 1);
    d_addr = 28'h0000077;
    tick();
    chk("chg_addr_hold", mem_addr, 28'h0000050);
    d_addr = 28'h0000099;
    run_grant("chg_done", 1, 0, 28'h0000050, '0, 128'h5050, 2, 1);

    // minimum turnaround: mem_ready on first BUSY cycle
    i_read = 1; i_addr = 28'h0000060;
    tick();
    chk("min_busy", mem_read, 1);
    chk("min_not_yet", i_ready, 0);
    mem_ready = 1; mem_rdata = 128'h600D;
    tick();
    mem_ready = 0;
    chk("min_ready", i_ready, 1);
    chk("min_rdata", i_rdata, 128'h600D);
    i_read = 0;
    tick();
    chk("min_ready_end", i_ready, 0);
    chk("min_idle_cmd", (mem_read | mem_write), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
